// File: rtl/serial_to_parallel_cond_pkg.sv
// Shared constants and state encoding for the serial receive path.
// Nothing here has ports. The state type is also used by the TX stage.
package serial_to_parallel_cond_pkg;

    localparam int         S2P_WIDTH      = 8;
    localparam logic [7:0] S2P_COMMA      = 8'hBC;
    localparam int         S2P_ACTIVE_CNT = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_cond_serial_shift8.sv
// serial_shift8: serial shift register plus byte bit counter.
// Ports: clk, reset_L, data_in, count_en in; sr_next, byte_done out.
module serial_shift8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             data_in,
    input  logic             count_en,
    output logic [WIDTH-1:0] sr_next,
    output logic             byte_done
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] bit_cnt;

    assign sr_next   = {sr[WIDTH-2:0], data_in};
    assign byte_done = count_en && (bit_cnt == LAST);

    // The counter idles at zero while hunting, so a comma hit
    // leaves it ready to count the first bit of the next byte.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr <= sr_next;
            if (!count_en || byte_done)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_to_parallel_cond.sv
// Serial receive stage: comma alignment, link-up and payload output.
// Ports: clk_8f, reset_L, data_in in; data_out, valid_out, active out.
module serial_to_parallel_cond
    import serial_to_parallel_cond_pkg::*;
#(
    parameter int         WIDTH      = S2P_WIDTH,
    parameter logic [7:0] COMMA      = S2P_COMMA,
    parameter int         ACTIVE_CNT = S2P_ACTIVE_CNT
) (
    input  logic             clk_8f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int            BC_W   = $clog2(ACTIVE_CNT + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(ACTIVE_CNT);

    s2p_state_t       state, state_n;
    logic [BC_W-1:0]  bc_cnt, bc_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             active_n;
    logic [WIDTH-1:0] sr_next;
    logic             byte_done;
    logic             is_comma;

    serial_shift8 #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (clk_8f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .count_en (state != HUNT),
        .sr_next  (sr_next),
        .byte_done(byte_done)
    );

    assign is_comma = (sr_next == COMMA[WIDTH-1:0]);

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state     <= HUNT;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            bc_cnt    <= bc_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= active_n;
        end
    end

    always_comb begin
        state_n  = state;
        bc_n     = bc_cnt;
        data_n   = data_out;
        valid_n  = valid_out;
        active_n = active;
        unique case (state)
            HUNT: begin
                // Any bit offset may match, garbage-overlapped ones included.
                if (is_comma) begin
                    state_n = ALIGNED;
                    bc_n    = BC_W'(1);
                end
            end
            ALIGNED: begin
                if (byte_done) begin
                    if (is_comma) begin
                        bc_n = bc_cnt + 1'b1;
                        if (bc_n == BC_MAX) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        state_n = HUNT;
                        bc_n    = '0;
                    end
                end
            end
            ACTIVE: begin
                // No loss-of-sync exit; only reset leaves this state.
                if (byte_done) begin
                    if (is_comma) begin
                        valid_n = 1'b0;
                    end else begin
                        data_n  = sr_next;
                        valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_to_parallel_cond.sv
// Randomized bench for serial_to_parallel_cond with a bit-history reference model.
// Drives bits on the falling edge, checks all outputs 1 time unit after each rising edge.
module tb_serial_to_parallel_cond;

    localparam logic [7:0] BC = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_checks = 0;
    int n_fail   = 0;

    serial_to_parallel_cond dut (
        .clk_8f   (clk_8f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_8f = ~clk_8f;

    // Reference model: last 8 received bits, the edge index at which a
    // comma locked alignment, and the count of aligned commas seen.
    bit         hist[$];
    int         t;
    int         lock_t;
    bit         locked;
    int         commas;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] last8();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            v[7-i] = hist[i];
        return v;
    endfunction

    task automatic model_step(input bit b, input bit rst_l);
        logic [7:0] byte_v;
        if (!rst_l) begin
            hist.delete();
            repeat (8) hist.push_back(1'b0);
            t        = 0;
            lock_t   = 0;
            locked   = 1'b0;
            commas   = 0;
            m_data   = 8'h00;
            m_valid  = 1'b0;
            m_active = 1'b0;
        end else begin
            hist.push_back(b);
            void'(hist.pop_front());
            t++;
            byte_v = last8();
            if (!locked) begin
                if (byte_v == BC) begin
                    locked = 1'b1;
                    lock_t = t;
                    commas = 1;
                end
            end else if (((t - lock_t) % 8) == 0) begin
                if (!m_active) begin
                    if (byte_v == BC) begin
                        commas++;
                        if (commas >= 4) m_active = 1'b1;
                    end else begin
                        locked = 1'b0;
                        commas = 0;
                    end
                end else if (byte_v != BC) begin
                    m_data  = byte_v;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic send_bit(input bit b, input bit rst_l);
        @(negedge clk_8f);
        data_in = b;
        reset_L = rst_l;
        @(posedge clk_8f);
        model_step(b, rst_l);
        #1;
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("active", 32'(active), 32'(m_active));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], 1'b1);
    endtask

    task automatic do_reset(input int n);
        repeat (n) send_bit(1'b1, 1'b0);
    endtask

    initial begin
        int r;
        logic [7:0] rb;

        // 1: reset with line idle high, then no commas
        do_reset(3);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_active", 32'(active), 32'h0);
        repeat (10) send_bit(1'b1, 1'b1);

        // 2: garbage then four commas
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        repeat (3) send_byte(BC);
        chk("pre_active", 32'(active), 32'h0);
        send_byte(BC);
        chk("link_up", 32'(active), 32'h1);

        // 3: two payload bytes
        send_byte(8'hA5);
        chk("p1_data", 32'(data_out), 32'hA5);
        send_byte(8'h3C);
        chk("p2_data", 32'(data_out), 32'h3C);
        chk("p2_valid", 32'(valid_out), 32'h1);

        // 4: payload followed by idle commas
        send_byte(8'hA5);
        send_byte(BC);
        chk("idle_valid", 32'(valid_out), 32'h0);
        chk("idle_hold", 32'(data_out), 32'hA5);
        send_byte(BC);
        chk("idle_active", 32'(active), 32'h1);

        // 5: broken preamble, then realign
        do_reset(2);
        repeat (3) send_byte(BC);
        send_byte(8'h00);
        chk("broken_valid", 32'(valid_out), 32'h0);
        repeat (4) send_byte(BC);
        send_byte(8'h7E);
        chk("realign_data", 32'(data_out), 32'h7E);
        chk("realign_valid", 32'(valid_out), 32'h1);

        // 6: reset mid-byte while active
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("mid_rst_active", 32'(active), 32'h0);
        chk("mid_rst_data", 32'(data_out), 32'h00);
        repeat (3) send_byte(BC);
        send_byte(8'h55);
        chk("no_payload", 32'(valid_out), 32'h0);
        repeat (4) send_byte(BC);
        send_byte(8'h55);
        chk("post_rst_data", 32'(data_out), 32'h55);

        // Random mix of resets, garbage, commas and payload
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                do_reset($urandom_range(1, 2));
            end else if (r == 1) begin
                repeat ($urandom_range(1, 7))
                    send_bit(1'($urandom_range(0, 1)), 1'b1);
            end else if (r <= 4) begin
                send_byte(BC);
            end else if (r == 5) begin
                repeat (4) send_byte(BC);
            end else begin
                rb = 8'($urandom_range(0, 255));
                send_byte(rb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
